// File: rtl/bitcoin_pkg.sv
// Shared types and constants for the nonce result scanner.
// The result record is RESULT_WORDS words long; REC_* give the offset of each field.
package bitcoin_pkg;
   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

   localparam int RESULT_WORDS = 4;

   localparam logic [1:0] REC_NONCE = 2'd0;
   localparam logic [1:0] REC_HASH  = 2'd1;
   localparam logic [1:0] REC_COUNT = 2'd2;
   localparam logic [1:0] REC_MASK  = 2'd3;
endpackage

// File: rtl/scan_accumulator.sv
// Single-cycle update of the running minimum, hit count and hit mask for one h0 word.
// Only a strictly smaller word replaces the minimum, so on a tie the lowest index is kept.
module scan_accumulator (
   input  logic [31:0] word,
   input  logic [4:0]  idx,
   input  logic [31:0] target,
   input  logic        first,
   input  logic [31:0] min_in,
   input  logic [4:0]  min_idx_in,
   input  logic [5:0]  count_in,
   input  logic [31:0] mask_in,
   output logic [31:0] min_out,
   output logic [4:0]  min_idx_out,
   output logic [5:0]  count_out,
   output logic [31:0] mask_out
);
   always_comb begin
      min_out     = min_in;
      min_idx_out = min_idx_in;
      count_out   = count_in;
      mask_out    = mask_in;
      if (word < target) begin
         count_out     = count_in + 6'd1;
         mask_out[idx] = 1'b1;
      end
      if (first || (word < min_in)) begin
         min_out     = word;
         min_idx_out = idx;
      end
   end
endmodule

// File: rtl/nonce_result_scanner.sv
// Reads NUM_RESULTS h0 words, tracks the minimum hash and target hits, then writes a
// 4-word record {nonce, hash, count, mask} to result_addr.
module nonce_result_scanner
   import bitcoin_pkg::*;
#(
   parameter int          NUM_RESULTS = 16,
   parameter logic [31:0] NONCE_BASE  = 32'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] hash_addr,
   input  logic [15:0] result_addr,
   input  logic [31:0] target,
   output logic        done,
   output logic        found,
   output logic [31:0] best_nonce,
   output logic [31:0] best_hash,
   output logic        mem_clk,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);
   localparam logic [5:0] LAST_RD = 6'(NUM_RESULTS);

   state_t      state, state_nx;
   logic [5:0]  rd, rd_nx;
   logic [1:0]  wr, wr_nx;
   logic [15:0] hash_base, hash_base_nx, res_base, res_base_nx;
   logic [31:0] tgt, tgt_nx;
   logic [31:0] min_val, min_val_nx;
   logic [4:0]  min_idx, min_idx_nx;
   logic [5:0]  count, count_nx;
   logic [31:0] mask, mask_nx;
   logic        first, first_nx;
   logic        found_nx;
   logic [31:0] best_nonce_nx, best_hash_nx;

   logic [5:0]  rd_m1;
   logic [31:0] acc_min;
   logic [4:0]  acc_idx;
   logic [5:0]  acc_count;
   logic [31:0] acc_mask;

   assign mem_clk = clk;
   assign done    = (state == IDLE);
   assign rd_m1   = rd - 6'd1;

   scan_accumulator u_acc (
      .word       (mem_read_data),
      .idx        (rd_m1[4:0]),
      .target     (tgt),
      .first      (first),
      .min_in     (min_val),
      .min_idx_in (min_idx),
      .count_in   (count),
      .mask_in    (mask),
      .min_out    (acc_min),
      .min_idx_out(acc_idx),
      .count_out  (acc_count),
      .mask_out   (acc_mask)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         rd         <= '0;
         wr         <= '0;
         hash_base  <= '0;
         res_base   <= '0;
         tgt        <= '0;
         min_val    <= '0;
         min_idx    <= '0;
         count      <= '0;
         mask       <= '0;
         first      <= 1'b0;
         found      <= 1'b0;
         best_nonce <= '0;
         best_hash  <= '0;
      end else begin
         state      <= state_nx;
         rd         <= rd_nx;
         wr         <= wr_nx;
         hash_base  <= hash_base_nx;
         res_base   <= res_base_nx;
         tgt        <= tgt_nx;
         min_val    <= min_val_nx;
         min_idx    <= min_idx_nx;
         count      <= count_nx;
         mask       <= mask_nx;
         first      <= first_nx;
         found      <= found_nx;
         best_nonce <= best_nonce_nx;
         best_hash  <= best_hash_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      rd_nx         = rd;
      wr_nx         = wr;
      hash_base_nx  = hash_base;
      res_base_nx   = res_base;
      tgt_nx        = tgt;
      min_val_nx    = min_val;
      min_idx_nx    = min_idx;
      count_nx      = count;
      mask_nx       = mask;
      first_nx      = first;
      found_nx      = found;
      best_nonce_nx = best_nonce;
      best_hash_nx  = best_hash;
      case (state)
         IDLE: if (start) begin
            hash_base_nx = hash_addr;
            res_base_nx  = result_addr;
            tgt_nx       = target;
            min_val_nx   = 32'hFFFF_FFFF;
            min_idx_nx   = '0;
            count_nx     = '0;
            mask_nx      = '0;
            first_nx     = 1'b1;
            rd_nx        = '0;
            state_nx     = READ;
         end
         READ: begin
            // rd=0 only issues the first address; data for word rd-1 arrives from rd=1 on
            if (rd != 6'd0) begin
               min_val_nx = acc_min;
               min_idx_nx = acc_idx;
               count_nx   = acc_count;
               mask_nx    = acc_mask;
               first_nx   = 1'b0;
            end
            if (rd == LAST_RD) begin
               wr_nx    = '0;
               state_nx = WRITE;
            end else begin
               rd_nx = rd + 6'd1;
            end
         end
         WRITE: begin
            wr_nx = wr + 2'd1;
            if (wr == REC_MASK) begin
               found_nx      = (count != 6'd0);
               best_nonce_nx = NONCE_BASE + {27'd0, min_idx};
               best_hash_nx  = min_val;
               state_nx      = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      mem_we         = (state == WRITE);
      mem_addr       = '0;
      mem_write_data = '0;
      if (state == READ)
         mem_addr = hash_base + {10'd0, rd};
      else if (state == WRITE) begin
         mem_addr = res_base + {14'd0, wr};
         case (wr)
            REC_NONCE: mem_write_data = NONCE_BASE + {27'd0, min_idx};
            REC_HASH:  mem_write_data = min_val;
            REC_COUNT: mem_write_data = {26'd0, count};
            default:   mem_write_data = mask;
         endcase
      end
   end
endmodule

// File: tb/tb_nonce_result_scanner.sv
// Scoreboard bench: a reference model pushes the expected record writes at each start,
// a negedge monitor pops and compares every write the DUT makes.
module tb_nonce_result_scanner;
   localparam int          N  = 16;
   localparam logic [31:0] NB = 32'd8;

   typedef struct packed {
      logic [15:0] a;
      logic [31:0] d;
   } wr_t;

   logic        clk = 0, reset = 1, start = 0;
   logic [15:0] hash_addr = 0, result_addr = 0;
   logic [31:0] target = 0;
   logic        done, found, mem_clk, mem_we;
   logic [31:0] best_nonce, best_hash, mem_write_data, mem_read_data;
   logic [15:0] mem_addr;

   logic [31:0] mem [0:65535];
   wr_t         exp_q[$];
   int          total = 0, bad = 0;
   logic        exp_found;
   logic [31:0] exp_nonce, exp_hash;

   nonce_result_scanner #(.NUM_RESULTS(N), .NONCE_BASE(NB)) dut (
      .clk(clk), .reset(reset), .start(start), .hash_addr(hash_addr),
      .result_addr(result_addr), .target(target), .done(done), .found(found),
      .best_nonce(best_nonce), .best_hash(best_hash), .mem_clk(mem_clk),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   always @(posedge mem_clk) begin
      mem_read_data <= mem[mem_addr];
      if (mem_we) mem[mem_addr] <= mem_write_data;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mem_we) begin
         if (exp_q.size() == 0) chk("extra_write", {16'd0, mem_addr}, 32'hDEAD_0000);
         else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", {16'd0, mem_addr}, {16'd0, e.a});
            chk("wr_data", mem_write_data, e.d);
         end
      end
   end

   task automatic model(input logic [15:0] hb, input logic [15:0] rb, input logic [31:0] tg);
      logic [31:0] mn = 32'hFFFF_FFFF, mk = 0, w, cnt = 0;
      int          mi = 0;
      wr_t         e;
      for (int k = 0; k < N; k++) begin
         w = mem[16'(hb + k)];
         if (w < tg) begin cnt++; mk[k] = 1'b1; end
         if (k == 0 || w < mn) begin mn = w; mi = k; end
      end
      exp_nonce = NB + 32'(mi);
      exp_hash  = mn;
      exp_found = (cnt != 0);
      e.a = rb;          e.d = exp_nonce; exp_q.push_back(e);
      e.a = 16'(rb + 1); e.d = mn;        exp_q.push_back(e);
      e.a = 16'(rb + 2); e.d = cnt;       exp_q.push_back(e);
      e.a = 16'(rb + 3); e.d = mk;        exp_q.push_back(e);
   endtask

   task automatic run_scan(input string tag, input logic [15:0] hb, input logic [15:0] rb,
                           input logic [31:0] tg, input bit pulse_mid);
      int cyc = 0;
      model(hb, rb, tg);
      @(negedge clk);
      hash_addr = hb; result_addr = rb; target = tg; start = 1;
      @(posedge clk); #1;
      start = 0;
      chk({tag, "_busy"}, {31'd0, done}, 0);
      do begin
         @(posedge clk); #1; cyc++;
         if (pulse_mid && cyc == 5) start = 1;
         if (pulse_mid && cyc == 6) start = 0;
      end while (!done && cyc < 100);
      chk({tag, "_latency"}, cyc, N + 5);
      chk({tag, "_found"}, {31'd0, found}, {31'd0, exp_found});
      chk({tag, "_nonce"}, best_nonce, exp_nonce);
      chk({tag, "_hash"}, best_hash, exp_hash);
      repeat (6) @(posedge clk);
      #1;
      chk({tag, "_idle"}, {31'd0, done}, 1);
      chk({tag, "_drained"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 32'd0;
      for (int k = 0; k < N; k++) begin
         mem[16'h0100 + k] = 32'h1000_0000 + k;
         mem[16'h0200 + k] = 32'hFFFF_0000;
         mem[16'h0300 + k] = (k == 9) ? 32'h1 : 32'h8000_0000;
         mem[16'(16'hFFF8 + k)] = $urandom | 32'h0000_0100;
         mem[16'h0500 + k] = 32'hFFFF_FFFF;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("rst_done", {31'd0, done}, 1);
      chk("rst_we", {31'd0, mem_we}, 0);
      chk("rst_found", {31'd0, found}, 0);
      chk("rst_nonce", best_nonce, 0);
      chk("rst_hash", best_hash, 0);
      reset = 0;

      run_scan("ramp", 16'h0100, 16'h0400, 32'h1000_0004, 0);
      chk("ramp_mem_mask", mem[16'h0403], 32'h0000_000F);
      run_scan("ties", 16'h0200, 16'h0410, 32'h0000_1000, 0);
      run_scan("one", 16'h0300, 16'h0420, 32'h0000_0002, 1);
      chk("one_nonce17", best_nonce, 32'd17);

      // abort a scan at rd=7; nothing may be written
      @(negedge clk);
      hash_addr = 16'h0100; result_addr = 16'h0600; target = 32'hFFFF_FFFF; start = 1;
      @(posedge clk); #1;
      start = 0;
      repeat (7) @(posedge clk);
      #1;
      reset = 1;
      #1;
      chk("abort_done", {31'd0, done}, 1);
      chk("abort_we", {31'd0, mem_we}, 0);
      chk("abort_found", {31'd0, found}, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
      chk("abort_nowrite", mem[16'h0600], 32'd0);
      run_scan("after", 16'h0300, 16'h0430, 32'h0000_0002, 0);

      run_scan("wrap", 16'hFFF8, 16'hFFFE, 32'h8000_0000, 0);
      run_scan("allff", 16'h0500, 16'h0440, 32'hFFFF_FFFF, 0);
      run_scan("zero", 16'h0100, 16'h0450, 32'h0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
